k16_frame_buffer_arbiter: RTL

//  Owns the 2048x16 text/colour frame buffer RAM and arbitrates its single port between the

---
 rtl/k16_frame_buffer_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/k16_frame_buffer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | k16_frame_buffer_arbiter                                                              |
// | Single-port 2048x16 frame buffer shared by video scan-out (priority) and the K16 CPU, |
// | with a full-buffer clear after every reset.                                           |
// | Revision: 1.0                                                                          |
// +--------------------------------------------------------------------------------------+
module k16_frame_buffer_arbiter #(
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] video_addr,
  input  logic                  video_req,
  output logic [DATA_WIDTH-1:0] video_data,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_req,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  clear_busy
);

  localparam int                    DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0] video_data_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;

  logic                  clear_wr;
  logic                  cpu_issue;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Video always owns the port in a cycle it requests; clear and CPU simply wait.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      S_CLEAR: begin
        if (!video_req) begin
          clear_ptr_d = clear_ptr_q + PTR_ONE;
          if (clear_ptr_q == PTR_MAX) begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (cpu_req && !video_req) begin
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    clear_wr   = (state_q == S_CLEAR) && !video_req;
    cpu_issue  = (state_q == S_IDLE) && cpu_req && !video_req;
    cpu_ack    = (state_q == S_ACK);
    clear_busy = (state_q == S_CLEAR);
    ram_we     = !reset && (clear_wr || (cpu_issue && cpu_we));
    ram_addr   = cpu_addr;
    ram_wdata  = cpu_wdata;
    if (video_req) begin
      ram_addr = video_addr;
    end else if (clear_wr) begin
      ram_addr  = clear_ptr_q;
      ram_wdata = CLEAR_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_data_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      if (video_req) begin
        video_data_q <= mem[ram_addr];
      end
      if (cpu_issue && !cpu_we) begin
        cpu_rdata_q <= mem[ram_addr];
      end
    end
  end

  assign video_data = video_data_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule
`default_nettype wire
